uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Transmit-side UART framer, counterpart to the receive path's start/data/parity/stop
//  checkers. Accepts a parallel word on a valid pulse and serialises it onto TX_OUT:
//  start(0), DATA_WIDTH data bits LSB-first, optional parity bit, STOP_BITS stop bits(1).
//  Bit timing comes from an internal prescale counter (PRESCALE CLK cycles per bit).
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame (5..9)
//  PRESCALE    16  CLK cycles per bit period (>=1)
//  STOP_BITS   1   number of stop bits (1 or 2)
// PORTS
//  CLK         in   1           system clock, rising edge
//  RSTn        in   1           asynchronous, active-low reset
//  P_DATA      in   DATA_WIDTH  parallel word to send
//  Data_Valid  in   1           request; accepted only in IDLE
//  PAR_EN      in   1           1 = insert parity bit
//  PAR_TYP     in   1           0 = even, 1 = odd parity
//  TX_OUT      out  1           serial line, idles high, registered
//  Busy        out  1           frame in progress, registered
// BEHAVIOUR
//  Reset (async, RSTn=0): TX_OUT=1, Busy=0, FSM=IDLE, all counters 0. Reset mid-frame
//   abandons the frame; line returns high immediately; no resume after release.
//  FSM: IDLE -> START -> DATA -> [PARITY if PAR_EN latched] -> STOP -> IDLE.
//  Acceptance: cycle N, FSM=IDLE and Data_Valid=1 -> latch P_DATA, PAR_EN, PAR_TYP,
//   compute parity; cycle N+1 FSM=START, TX_OUT=0, Busy=1.
//  Each state holds TX_OUT for exactly PRESCALE cycles (prescale cnt 0..PRESCALE-1,
//   advance on terminal count). DATA repeats DATA_WIDTH bit periods, bit cnt 0..DATA_WIDTH-1,
//   TX_OUT = shreg[0], shift right per bit. STOP lasts STOP_BITS*PRESCALE cycles, TX_OUT=1.
//  Parity: even -> ^data; odd -> ~^data. Computed from the latched word.
//  Busy=1 from first START cycle through last STOP cycle; 0 in IDLE.
//  Frame length = (1+DATA_WIDTH+PAR_EN+STOP_BITS)*PRESCALE cycles of Busy=1.
//  Data_Valid while Busy=1: ignored, not queued. P_DATA/PAR_* changes mid-frame: no effect.
//  Back-to-back: Data_Valid held high -> after STOP, one IDLE cycle (TX_OUT=1, Busy=0,
//   accepts) then next START; i.e. exactly 1 extra high CLK between frames.
//  PRESCALE=1: every state lasts one cycle; counters must not wrap incorrectly.
//  Counter widths: $clog2 of max value, min 1 bit; no arithmetic overflow permitted.
// STRUCTURE
//  Package uart_pkg: FSM state enum (IDLE/START/DATA/PARITY/STOP), PAR_EVEN/PAR_ODD
//   constants; shared with the receive path.
//  Sub-module uart_tx_parity_calc (combinational: data, typ -> parity bit), reusable by
//   the receive parity checker. Prescale counter, bit counter, shreg, FSM stay in top.
// TESTING  (DATA_WIDTH=8, PRESCALE=4, STOP_BITS=1 unless stated)
//  1 P_DATA=0xA5, PAR_EN=0, 1-cycle Data_Valid -> TX_OUT 0,1,0,1,0,0,1,0,1,1 each 4 clk;
//    Busy=1 for 40 clk; back to TX_OUT=1, Busy=0.
//  2 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, Busy 44 clk; PAR_TYP=1 -> parity bit 1.
//  3 Data_Valid held high, 0x3C then 0xC3 -> two frames, exactly 1 IDLE clk between;
//    second frame's data ignored changes while first Busy.
//  4 Pulse Data_Valid with P_DATA=0xFF mid-frame of 0x00 -> ignored, 0x00 frame intact.
//  5 RSTn low at DATA bit 3 -> TX_OUT=1, Busy=0 asynchronously; after release, idle until
//    new Data_Valid; next frame well-formed.
//  6 PRESCALE=1, STOP_BITS=2, 0x01 -> 0,1,0,0,0,0,0,0,0,1,1 one clk each, Busy 11 clk.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and parity-type encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator; also usable by the receive-side parity checker.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  typ,
  output logic                  par_c
);

  assign par_c = (typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit(s),
// each bit held for PRESCALE clocks.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned PW = (PRESCALE > 1)   ? $clog2(PRESCALE)   : 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned SW = (STOP_BITS > 1)  ? $clog2(STOP_BITS)  : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] STOP_LAST  = SW'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [SW-1:0]         stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_c;
  logic                  presc_tc_c;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data (P_DATA),
    .typ  (PAR_TYP),
    .par_c(par_c)
  );

  assign presc_tc_c = (presc_q == PRESC_LAST);

  // Next-state logic; TX_OUT/Busy are computed for the coming cycle so they leave a flop.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q != IDLE) begin
      presc_d = presc_tc_c ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          state_d   = START;
          shreg_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = par_c;
          presc_d   = '0;
          bit_d     = '0;
          stop_d    = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (presc_tc_c) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (presc_tc_c) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (presc_tc_c) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (presc_tc_c) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            stop_d  = '0;
            busy_d  = 1'b0;
          end else begin
            stop_d = stop_q + SW'(1);
          end
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      bit_q     <= '0;
      stop_q    <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two configurations compared every clock against a
// queue-based waveform model of the serial line.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [7:0] pd;
  logic       pe, pt;
  logic       dv1, dv2;
  logic       tx1, busy1, tx2, busy2;

  int errs   = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(4), .STOP_BITS(1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .P_DATA(pd), .Data_Valid(dv1), .PAR_EN(pe),
    .PAR_TYP(pt), .TX_OUT(tx1), .Busy(busy1));

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(1), .STOP_BITS(2)) u_dut2 (
    .CLK(CLK), .RSTn(RSTn), .P_DATA(pd), .Data_Valid(dv2), .PAR_EN(pe),
    .PAR_TYP(pt), .TX_OUT(tx2), .Busy(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line sequence of one frame, one entry per bit period.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic par_en,
                                             input logic par_odd, input int sb,
                                             output int n);
    logic [15:0] b = '1;
    int k = 0;
    b[k] = 1'b0; k++;
    for (int i = 0; i < 8; i++) begin b[k] = d[i]; k++; end
    if (par_en) begin b[k] = par_odd ? ~(^d) : (^d); k++; end
    for (int i = 0; i < sb; i++) begin b[k] = 1'b1; k++; end
    n = k;
    return b;
  endfunction

  // Expected line per clock; an empty queue means the transmitter is idle.
  logic        q1[$];
  logic        q2[$];
  logic        idle1, idle2;
  logic [15:0] fb1, fb2;
  int          n1, n2;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q1.delete();
      q2.delete();
    end else begin
      idle1 = (q1.size() == 0);
      idle2 = (q2.size() == 0);
      if (!idle1) void'(q1.pop_front());
      if (!idle2) void'(q2.pop_front());
      if (idle1 && dv1) begin
        fb1 = frame_bits(pd, pe, pt, 1, n1);
        for (int i = 0; i < n1; i++) for (int j = 0; j < 4; j++) q1.push_back(fb1[i]);
      end
      if (idle2 && dv2) begin
        fb2 = frame_bits(pd, pe, pt, 2, n2);
        for (int i = 0; i < n2; i++) q2.push_back(fb2[i]);
      end
    end
  end

  int run_busy1 = 0, run_idle1 = 0, last_len1 = 0, last_gap1 = 0;
  int run_busy2 = 0, last_len2 = 0;

  // Per-cycle comparison and Busy/idle run-length tracking, away from the active edge.
  always @(negedge CLK) begin
    chk("tx1",   32'(tx1),   32'((q1.size() == 0) ? 1'b1 : q1[0]));
    chk("busy1", 32'(busy1), 32'(q1.size() != 0));
    chk("tx2",   32'(tx2),   32'((q2.size() == 0) ? 1'b1 : q2[0]));
    chk("busy2", 32'(busy2), 32'(q2.size() != 0));
    if (busy1 === 1'b1) begin
      if (run_idle1 > 0) last_gap1 = run_idle1;
      run_idle1 = 0;
      run_busy1++;
    end else begin
      if (run_busy1 > 0) last_len1 = run_busy1;
      run_busy1 = 0;
      run_idle1++;
    end
    if (busy2 === 1'b1) run_busy2++;
    else begin
      if (run_busy2 > 0) last_len2 = run_busy2;
      run_busy2 = 0;
    end
  end

  task automatic pulse(input int which, input logic [7:0] d, input logic e,
                       input logic t, input int hold);
    @(posedge CLK); #1;
    pd = d; pe = e; pt = t;
    if (which == 1) dv1 = 1'b1; else dv2 = 1'b1;
    repeat (hold) @(posedge CLK);
    #1;
    dv1 = 1'b0;
    dv2 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (which == 1 && busy1 === 1'b0) break;
      if (which == 2 && busy2 === 1'b0) break;
    end
    if (k == 200) chk("idle_timeout", 32'(k), 32'(0));
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    RSTn = 1'b0; dv1 = 1'b0; dv2 = 1'b0; pd = '0; pe = 1'b0; pt = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx1", 32'(tx1), 32'(1));
    chk("rst_busy1", 32'(busy1), 32'(0));
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);

    // Plain 0xA5 frame, then with even and odd parity
    pulse(1, 8'hA5, 1'b0, 1'b0, 1);
    wait_idle(1);
    chk("len_nopar", 32'(last_len1), 32'(40));
    pulse(1, 8'hA5, 1'b1, 1'b0, 1);
    repeat (37) @(negedge CLK);
    chk("par_even", 32'(tx1), 32'(0));
    wait_idle(1);
    chk("len_par", 32'(last_len1), 32'(44));
    pulse(1, 8'hA5, 1'b1, 1'b1, 1);
    repeat (37) @(negedge CLK);
    chk("par_odd", 32'(tx1), 32'(1));
    wait_idle(1);

    // Back-to-back with Data_Valid held; data changes while busy are ignored
    @(posedge CLK); #1;
    pd = 8'h3C; pe = 1'b0; pt = 1'b0; dv1 = 1'b1;
    repeat (3) @(posedge CLK);
    #1 pd = 8'h55;
    repeat (10) @(posedge CLK);
    #1 pd = 8'hC3;
    for (int k = 0; k < 100 && busy1 !== 1'b0; k++) @(negedge CLK);
    @(posedge CLK); #1 dv1 = 1'b0;
    wait_idle(1);
    chk("b2b_gap", 32'(last_gap1), 32'(1));

    // Mid-frame request is dropped
    pulse(1, 8'h00, 1'b0, 1'b0, 1);
    repeat (10) @(negedge CLK);
    pulse(1, 8'hFF, 1'b1, 1'b1, 1);
    wait_idle(1);
    chk("len_ignore", 32'(last_len1), 32'(40));

    // Asynchronous reset during data bit 3
    pulse(1, 8'hA5, 1'b0, 1'b0, 1);
    repeat (18) @(negedge CLK);
    chk("pre_rst_tx", 32'(tx1), 32'(0));
    #1 RSTn = 1'b0;
    #1;
    chk("async_tx", 32'(tx1), 32'(1));
    chk("async_busy", 32'(busy1), 32'(0));
    @(negedge CLK); RSTn = 1'b1;
    repeat (10) @(negedge CLK);
    pulse(1, 8'h5A, 1'b1, 1'b0, 1);
    wait_idle(1);
    chk("len_after_rst", 32'(last_len1), 32'(44));

    // PRESCALE=1, two stop bits
    pulse(2, 8'h01, 1'b0, 1'b0, 1);
    wait_idle(2);
    chk("len_p1", 32'(last_len2), 32'(11));

    // Randomized frames on both configurations
    for (int r = 0; r < 25; r++) begin
      pulse(1, 8'($urandom), 1'($urandom), 1'($urandom), 1 + int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(posedge CLK);
        pulse(1, 8'($urandom), 1'($urandom), 1'($urandom), 1);
      end
      wait_idle(1);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    for (int r = 0; r < 25; r++) begin
      pulse(2, 8'($urandom), 1'($urandom), 1'($urandom), 1 + int'($urandom_range(0, 14)));
      wait_idle(2);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
